// File: rtl/madd_err_accum.sv
// madd_err_accum: error metrics over a stream of (exact, approx) multiply-add results
// Optional macro MADD_ERR_SQ_EN adds a sum-of-squared-error output.
module madd_err_accum #(
    parameter int W     = 12,
    parameter int CNT_W = 18,
    parameter int SUM_W = W + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_exact,
    input  logic [W-1:0]     in_approx,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [W-1:0]     max_abs_err,
`ifdef MADD_ERR_SQ_EN
    output logic [2*W+CNT_W-1:0] sum_sq_err,
`endif
    output logic             cnt_ovf
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             accept;
    logic [W:0]       diff, mag;
    logic             s1_vld_q, s1_vld_d, s1_neq_q, s1_neq_d;
    logic [W-1:0]     s1_abs_q, s1_abs_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0] sum_abs_q, sum_abs_d;
    logic [W-1:0]     max_abs_q, max_abs_d;
    logic             cnt_ovf_q, cnt_ovf_d;
`ifdef MADD_ERR_SQ_EN
    logic [2*W-1:0]       s1_sq_q, s1_sq_d;
    logic [2*W+CNT_W-1:0] sum_sq_q, sum_sq_d;
`endif

    // Outputs decoded from the current state; metrics come straight from flops
    always_comb begin
        in_ready    = state_q == S_RUN;
        busy        = state_q == S_RUN || state_q == S_DRAIN;
        done        = state_q == S_DONE;
        accept      = in_valid && in_ready;
        sample_cnt  = sample_cnt_q;
        err_cnt     = err_cnt_q;
        sum_abs_err = sum_abs_q;
        max_abs_err = max_abs_q;
        cnt_ovf     = cnt_ovf_q;
`ifdef MADD_ERR_SQ_EN
        sum_sq_err  = sum_sq_q;
`endif
    end

    // Next state: start always (re)enters RUN; DRAIN leaves once stage 1 empties
    always_comb begin
        state_d = state_q;
        if (start)
            state_d = S_RUN;
        else if (state_q == S_RUN)
            state_d = (accept && in_last) ? S_DRAIN : S_RUN;
        else if (state_q == S_DRAIN)
            state_d = s1_vld_d ? S_DRAIN : S_DONE;
    end

    // Stage 1: magnitude of the widened difference and inequality flag
    always_comb begin
        diff     = {1'b0, in_exact} - {1'b0, in_approx};
        mag      = diff[W] ? -diff : diff;
        s1_abs_d = mag[W-1:0];
        s1_neq_d = in_exact != in_approx;
        s1_vld_d = accept && !start;
`ifdef MADD_ERR_SQ_EN
        s1_sq_d  = (2*W)'(s1_abs_d) * (2*W)'(s1_abs_d);
`endif
    end

    // Stage 2 accumulators plus the accept-time sample counter; start clears everything
    always_comb begin
        sample_cnt_d = start ? '0 : (accept && sample_cnt_q != CNT_MAX) ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
        cnt_ovf_d    = start ? 1'b0 : cnt_ovf_q || (accept && sample_cnt_q == CNT_MAX - CNT_W'(1));
        err_cnt_d    = start ? '0 : (s1_vld_q && s1_neq_q && err_cnt_q != CNT_MAX) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        sum_abs_d    = start ? '0 : s1_vld_q ? sum_abs_q + SUM_W'(s1_abs_q) : sum_abs_q;
        max_abs_d    = start ? '0 : (s1_vld_q && s1_abs_q > max_abs_q) ? s1_abs_q : max_abs_q;
`ifdef MADD_ERR_SQ_EN
        sum_sq_d     = start ? '0 : s1_vld_q ? sum_sq_q + (2*W+CNT_W)'(s1_sq_q) : sum_sq_q;
`endif
    end

    // State, pipeline and metric registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            s1_vld_q     <= 1'b0;
            s1_neq_q     <= 1'b0;
            s1_abs_q     <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_abs_q    <= '0;
            max_abs_q    <= '0;
            cnt_ovf_q    <= 1'b0;
`ifdef MADD_ERR_SQ_EN
            s1_sq_q      <= '0;
            sum_sq_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            s1_vld_q     <= s1_vld_d;
            s1_neq_q     <= s1_neq_d;
            s1_abs_q     <= s1_abs_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_abs_q    <= sum_abs_d;
            max_abs_q    <= max_abs_d;
            cnt_ovf_q    <= cnt_ovf_d;
`ifdef MADD_ERR_SQ_EN
            s1_sq_q      <= s1_sq_d;
            sum_sq_q     <= sum_sq_d;
`endif
        end
    end
endmodule

// File: tb/tb_madd_err_accum.sv
// tb_madd_err_accum: table, directed and randomized checks of madd_err_accum
module tb_madd_err_accum;
    logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
    logic [11:0] in_exact = 0, in_approx = 0;
    logic        in_ready, busy, done, cnt_ovf;
    logic [17:0] sample_cnt, err_cnt;
    logic [29:0] sum_abs_err;
    logic [11:0] max_abs_err;
    logic        s_ready, s_busy, s_done, s_ovf;
    logic [5:0]  s_cnt, s_err;
    logic [17:0] s_sum;
    logic [11:0] s_max;
`ifdef MADD_ERR_SQ_EN
    logic [41:0] sum_sq_err;
    logic [29:0] s_sq;
`endif
    int checks = 0, errors = 0;
    int q_e[$], q_a[$];

    always #5 clk = ~clk;

    madd_err_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_exact(in_exact), .in_approx(in_approx), .in_last(in_last), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err),
`ifdef MADD_ERR_SQ_EN
        .sum_sq_err(sum_sq_err),
`endif
        .cnt_ovf(cnt_ovf));

    // Small-counter instance shares the stimulus so saturation is reachable quickly
    madd_err_accum #(.W(12), .CNT_W(6), .SUM_W(18)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_ready),
        .in_exact(in_exact), .in_approx(in_approx), .in_last(in_last), .busy(s_busy), .done(s_done),
        .sample_cnt(s_cnt), .err_cnt(s_err), .sum_abs_err(s_sum), .max_abs_err(s_max),
`ifdef MADD_ERR_SQ_EN
        .sum_sq_err(s_sq),
`endif
        .cnt_ovf(s_ovf));

    typedef struct { int e; int a; int abs_e; int neq; } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
        q_e.delete();
        q_a.delete();
    endtask

    task automatic send(input int e, input int a, input bit last);
        in_valid = 1; in_exact = 12'(e); in_approx = 12'(a); in_last = last;
        tick();
        in_valid = 0; in_last = 0;
        q_e.push_back(e);
        q_a.push_back(a);
    endtask

    // After the last accept: one cycle of DRAIN, then done
    task automatic expect_done(input string name);
        chk({name, "_drain_done"}, done, 0);
        chk({name, "_drain_ready"}, in_ready, 0);
        tick();
        chk({name, "_done"}, done, 1);
        chk({name, "_busy"}, busy, 0);
    endtask

    task automatic chk_metrics(input string name, input longint sc, input longint ec,
                               input longint sm, input longint mx, input longint ov);
        chk({name, "_sample_cnt"}, sample_cnt, sc);
        chk({name, "_err_cnt"}, err_cnt, ec);
        chk({name, "_sum_abs"}, sum_abs_err, sm);
        chk({name, "_max_abs"}, max_abs_err, mx);
        chk({name, "_cnt_ovf"}, cnt_ovf, ov);
    endtask

    // Reference: metrics recomputed from the list of accepted pairs
    task automatic model_check(input string name);
        longint n, ec, sm, mx, d;
        n = q_e.size(); ec = 0; sm = 0; mx = 0;
        foreach (q_e[i]) begin
            d = q_e[i] > q_a[i] ? q_e[i] - q_a[i] : q_a[i] - q_e[i];
            sm += d;
            if (d > mx) mx = d;
            if (d != 0) ec++;
        end
        chk_metrics(name, n, ec, sm, mx, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{7, 7, 0, 0};
        tbl[1] = '{0, 4095, 4095, 1};
        tbl[2] = '{4095, 0, 4095, 1};
        tbl[3] = '{2048, 2047, 1, 1};
        tbl[4] = '{0, 0, 0, 0};
        tbl[5] = '{1000, 3000, 2000, 1};

        #3;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk_metrics("rst", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1;
        repeat (3) tick();
        chk("idle_no_start_ready", in_ready, 0);
        chk("idle_no_start_busy", busy, 0);

        do_start();
        chk("run_ready", in_ready, 1);
        chk("run_busy", busy, 1);
        send(100, 100, 0);
        send(100, 97, 0);
        send(5, 12, 0);
        send(4095, 0, 1);
        expect_done("basic");
        chk_metrics("basic", 4, 3, 4105, 4095, 0);
`ifdef MADD_ERR_SQ_EN
        chk("basic_sum_sq", sum_sq_err, 16769083);
`endif
        in_valid = 1; in_exact = 1; in_approx = 2;
        repeat (3) tick();
        in_valid = 0;
        chk("frozen_done", done, 1);
        chk_metrics("frozen", 4, 3, 4105, 4095, 0);

        foreach (tbl[i]) begin
            do_start();
            send(tbl[i].e, tbl[i].a, 1);
            tick();
            chk($sformatf("tbl%0d_done", i), done, 1);
            chk_metrics($sformatf("tbl%0d", i), 1, tbl[i].neq, tbl[i].abs_e, tbl[i].abs_e, 0);
        end

        do_start();
        for (int i = 0; i < 8; i++) begin
            send(i * 100 + 1, i * 100, i == 7);
            if (i != 7) begin
                in_exact = 12'($urandom); in_approx = 12'($urandom);
                tick();
            end
        end
        expect_done("gaps");
        chk_metrics("gaps", 8, 8, 8, 1, 0);

        do_start();
        send(50, 40, 0);
        send(40, 50, 0);
        start = 1;
        send(4095, 0, 0);
        start = 0;
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 1);
        chk("abort_cnt", sample_cnt, 0);
        send(10, 3, 0);
        send(3, 10, 0);
        send(9, 9, 1);
        expect_done("abort");
        chk_metrics("abort", 3, 2, 14, 7, 0);

        do_start();
        for (int i = 0; i < 64; i++) send(4095, 0, i == 63);
        expect_done("sat");
        chk_metrics("sat", 64, 64, 4095 * 64, 4095, 0);
        chk("sat_small_cnt", s_cnt, 63);
        chk("sat_small_err", s_err, 63);
        chk("sat_small_ovf", s_ovf, 1);
        chk("sat_small_sum", s_sum, 4095 * 64);
        chk("sat_small_max", s_max, 4095);
        chk("sat_small_done", s_done, 1);

        do_start();
        chk("restart_ovf_clr", s_ovf, 0);
        send(7, 7, 1);
        expect_done("restart");
        chk_metrics("restart", 1, 0, 0, 0, 0);

        for (int r = 0; r < 10; r++) begin
            int n;
            do_start();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                int e, a;
                while ($urandom_range(0, 3) == 0) begin
                    in_exact = 12'($urandom); in_approx = 12'($urandom);
                    tick();
                end
                e = $urandom_range(0, 4095);
                a = $urandom_range(0, 2) == 0 ? e : $urandom_range(0, 1) ? $urandom_range(0, 4095)
                    : (e + $urandom_range(0, 8)) % 4096;
                send(e, a, i == n - 1);
            end
            expect_done($sformatf("rnd%0d", r));
            model_check($sformatf("rnd%0d", r));
        end

        do_start();
        send(300, 100, 0);
        send(1, 2, 0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_ready", in_ready, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk_metrics("async_rst", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1;
        repeat (2) tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", in_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/madd_err_accum.md
Name: madd_err_accum

Overview:
- Downstream error-evaluation stage for approximate multiply-add netlists (6x6 multiply plus 6-bit addend, 12-bit result).
- Consumes a stream of (exact, approximate) 12-bit result pairs produced by the exhaustive sweep over the 18 primary inputs.
- Accumulates error metrics over one run: error count, sum of absolute error, maximum absolute error.
- Holds the final metrics stable for readout until the next start.

Parameters:
- W, 12, result width of the exact and approximate operands.
- CNT_W, 18, sample counter width (2^18 = exhaustive sweep of 18 inputs).
- SUM_W, 30, absolute-error accumulator width; must be W+CNT_W so it cannot overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clears metrics and begins a run.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  stage accepts a sample.
- in_exact  in  W  exact result.
- in_approx  in  W  approximate result.
- in_last  in  1  marks the final sample of the run.
- busy  out  1  run in progress (RUN or DRAIN).
- done  out  1  metrics final; held high until next start.
- sample_cnt  out  CNT_W  accepted samples (saturating).
- err_cnt  out  CNT_W  samples with exact != approx (saturating).
- sum_abs_err  out  SUM_W  sum of |exact - approx|.
- max_abs_err  out  W  maximum |exact - approx|.
- cnt_ovf  out  1  sticky: the sample counter saturated.

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0, including in_ready, busy, done, all counters and cnt_ovf. Pipeline valid bit cleared.
- States:
  - IDLE: in_ready=0. start -> RUN, clearing all metrics, done, cnt_ovf and the pipeline.
  - RUN: in_ready=1. A sample is accepted when in_valid & in_ready.
  - Accepted sample with in_last=1 -> DRAIN; in_ready drops the next cycle.
  - DRAIN: in_ready=0. Waits for the pipeline to empty, then -> DONE.
  - DONE: done=1, metrics frozen. start -> RUN, with the same clearing as from IDLE.
- Pipeline: 2 stages.
  - Stage 1 registers abs_diff = |exact - approx| (W+1-bit signed subtract, magnitude truncated to W bits, exact since both operands are W-bit unsigned) and neq = (exact != approx).
  - Stage 2 updates the accumulators.
- Latency: done rises 2 cycles after the cycle that accepted the in_last sample.
- Arithmetic:
  - sum_abs_err += abs_diff, zero-extended.
  - max_abs_err = max(max, abs_diff), unsigned compare; equal values leave it unchanged.
  - err_cnt += neq.
- Saturation:
  - sample_cnt stops at 2^CNT_W-1; the accepting cycle that reaches that value sets cnt_ovf.
  - err_cnt saturates at the same value.
  - sum_abs_err is sized so it never wraps.
- in_valid while in_ready=0: ignored, no accept.
- Data inputs are don't-care when in_valid=0.
- start while in RUN or DRAIN: aborts the run. All metrics cleared, state RUN, pipeline flushed, done stays 0.
- start and an accept in the same cycle: start wins; the sample is discarded.
- in_last on the first sample: valid run of 1 sample.
- busy = (state==RUN) | (state==DRAIN).
- Metric outputs are registered and update live during RUN.
- rst_n asserted mid-run: immediate return to IDLE, all outputs 0.

Optional Feature:
- Macro: MADD_ERR_SQ_EN.
- Defined:
  - Adds output sum_sq_err [2*W+CNT_W-1:0], the sum of abs_diff^2.
  - The square is computed in stage 1 and accumulated in stage 2, so latency is unchanged.
  - Cleared and reset like the other metrics.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset with rst_n=0 mid-stream -> all outputs 0, in_ready=0; release, no start -> remains IDLE.
- start; 4 samples (exact,approx) = (100,100),(100,97),(5,12),(4095,0) with last on the 4th -> done 2 cycles after the last accept:
  - sample_cnt=4, err_cnt=3, sum_abs_err=4105, max_abs_err=4095.
  - With MADD_ERR_SQ_EN: sum_sq_err=16769083.
- in_valid toggled 1/0 each cycle over 8 samples, all with exact=approx+1 -> err_cnt=8, sum_abs_err=8, max_abs_err=1; gaps add nothing.
- start pulsed on the 3rd of 6 samples -> metrics cleared, that sample dropped; the next 3 samples counted, sample_cnt=3 at done.
- Sweep of 2^18 samples, every one with |err|=4095 -> sample_cnt=err_cnt=262143, cnt_ovf=1, max_abs_err=4095, sum_abs_err=4095*262144 (the sum counts every accepted sample).
- Run to DONE, then start again with 1 sample (7,7) last -> done, sample_cnt=1, err_cnt=0, max_abs_err=0, sum_abs_err=0.
